// File: rtl/lif_pkg.sv
// Shared types and default constants for the leaky integrate-and-fire layer.
package lif_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StUpdate,
    StOut
  } lif_state_e;

  localparam int unsigned DefVwidth    = 10;
  localparam int unsigned DefThreshold = 16;
  localparam int unsigned DefLeakShift = 2;
  localparam int unsigned RefrLoad     = 2;

endpackage

// File: rtl/lif_layer_update.sv
// Single-neuron datapath: leak, add current, saturate, compare against threshold.
module lif_update #(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned VWIDTH     = lif_pkg::DefVwidth,
  parameter int unsigned THRESHOLD  = lif_pkg::DefThreshold,
  parameter int unsigned LEAK_SHIFT = lif_pkg::DefLeakShift
) (
  input  logic [VWIDTH-1:0]    v_i,
  input  logic [DATAWIDTH-1:0] c_i,
  output logic [VWIDTH-1:0]    v_next_o,
  output logic                 spike_o
);

  // One spare bit above the wider operand so the add cannot wrap before saturation.
  localparam int unsigned SumW = ((DATAWIDTH > VWIDTH) ? DATAWIDTH : VWIDTH) + 1;
  localparam logic [SumW-1:0] VMax = {{(SumW - VWIDTH){1'b0}}, {VWIDTH{1'b1}}};
  localparam logic [VWIDTH-1:0] Thr = VWIDTH'(THRESHOLD);

  logic [VWIDTH-1:0] leaked;
  logic [SumW-1:0]   sum;
  logic [VWIDTH-1:0] v_sat;

  always_comb begin
    leaked   = v_i - (v_i >> LEAK_SHIFT);
    sum      = SumW'(leaked) + SumW'(c_i);
    v_sat    = (sum > VMax) ? VMax[VWIDTH-1:0] : sum[VWIDTH-1:0];
    spike_o  = (v_sat >= Thr);
    v_next_o = spike_o ? '0 : v_sat;
  end

endmodule

// File: rtl/lif_layer.sv
// LIF neuron layer: latches a current frame, updates one neuron per cycle, emits a spike frame.
// Define LIF_REFRACTORY_EN to add a 2-frame refractory period after each spike.
module lif_layer
  import lif_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned NEURONS    = 16,
  parameter int unsigned VWIDTH     = DefVwidth,
  parameter int unsigned THRESHOLD  = DefThreshold,
  parameter int unsigned LEAK_SHIFT = DefLeakShift
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATAWIDTH*NEURONS-1:0]   c_in,
  input  logic                           c_valid,
  output logic                           c_ready,
  output logic [DATAWIDTH*NEURONS-1:0]   spike_out,
  output logic                           spike_valid,
  input  logic                           spike_ready
);

  localparam int unsigned IdxW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  lif_state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic c_ready_q, c_ready_d;
  logic spike_valid_q, spike_valid_d;
  logic [DATAWIDTH*NEURONS-1:0] c_q;
  logic [DATAWIDTH*NEURONS-1:0] spike_q;
  logic [VWIDTH-1:0] v_q [NEURONS];

  logic accept;
  logic last_idx;
  logic [DATAWIDTH-1:0] c_cur;
  logic [VWIDTH-1:0] v_cur, v_upd;
  logic spk_upd;

  assign accept   = (state_q == StIdle) && c_valid && c_ready_q;
  assign last_idx = (idx_q == IdxW'(NEURONS - 1));
  assign c_cur    = c_q[idx_q*DATAWIDTH +: DATAWIDTH];
  assign v_cur    = v_q[idx_q];

  lif_update #(
    .DATAWIDTH  (DATAWIDTH),
    .VWIDTH     (VWIDTH),
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_update (
    .v_i      (v_cur),
    .c_i      (c_cur),
    .v_next_o (v_upd),
    .spike_o  (spk_upd)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StUpdate;
          idx_d   = '0;
        end
      end
      StUpdate: begin
        if (last_idx) state_d = StOut;
        else          idx_d   = idx_q + 1'b1;
      end
      StOut: begin
        if (spike_valid_q && spike_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Outputs are registered so reset can hold c_ready low while the FSM sits in idle.
    c_ready_d     = (state_d == StIdle);
    spike_valid_d = (state_q == StOut) && !(spike_valid_q && spike_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      c_ready_q     <= 1'b0;
      spike_valid_q <= 1'b0;
      c_q           <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      c_ready_q     <= c_ready_d;
      spike_valid_q <= spike_valid_d;
      if (accept) c_q <= c_in;
    end
  end

`ifdef LIF_REFRACTORY_EN
  logic [1:0] refr_q [NEURONS];
  logic refr_busy;
  assign refr_busy = (refr_q[idx_q] != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned j = 0; j < NEURONS; j++) begin
        v_q[j]    <= '0;
        refr_q[j] <= '0;
      end
      spike_q <= '0;
    end else if (state_q == StUpdate) begin
      if (refr_busy) begin
        v_q[idx_q]    <= '0;
        refr_q[idx_q] <= refr_q[idx_q] - 2'd1;
        spike_q[idx_q*DATAWIDTH +: DATAWIDTH] <= '0;
      end else begin
        v_q[idx_q] <= v_upd;
        if (spk_upd) refr_q[idx_q] <= 2'(RefrLoad);
        spike_q[idx_q*DATAWIDTH +: DATAWIDTH] <= DATAWIDTH'(spk_upd);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned j = 0; j < NEURONS; j++) begin
        v_q[j] <= '0;
      end
      spike_q <= '0;
    end else if (state_q == StUpdate) begin
      v_q[idx_q] <= v_upd;
      spike_q[idx_q*DATAWIDTH +: DATAWIDTH] <= DATAWIDTH'(spk_upd);
    end
  end
`endif

  assign c_ready     = c_ready_q;
  assign spike_valid = spike_valid_q;
  assign spike_out   = spike_q;

endmodule

// File: tb/tb_lif_layer.sv
// Self-checking bench for lif_layer: frame-level reference model plus directed boundary cases.
module tb_lif_layer;

  localparam int DW = 8;
  localparam int N  = 16;
  localparam int VW = 10;
  localparam int TH = 16;
  localparam int LS = 2;
  localparam int W  = DW * N;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] c_in = '0;
  logic c_valid = 1'b0;
  logic c_ready;
  logic [W-1:0] spike_out;
  logic spike_valid;
  logic spike_ready = 1'b1;

  logic [W-1:0] c8 = '0;
  logic c8_valid = 1'b0;
  logic c8_ready;
  logic [W-1:0] s8_out;
  logic s8_valid;
  logic s8_ready = 1'b1;

  always #5 clk = ~clk;

  lif_layer dut (
    .clk         (clk),
    .rst         (rst),
    .c_in        (c_in),
    .c_valid     (c_valid),
    .c_ready     (c_ready),
    .spike_out   (spike_out),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready)
  );

  lif_layer #(
    .DATAWIDTH  (8),
    .NEURONS    (16),
    .VWIDTH     (8),
    .THRESHOLD  (255),
    .LEAK_SHIFT (2)
  ) dut8 (
    .clk         (clk),
    .rst         (rst),
    .c_in        (c8),
    .c_valid     (c8_valid),
    .c_ready     (c8_ready),
    .spike_out   (s8_out),
    .spike_valid (s8_valid),
    .spike_ready (s8_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lif_next(input int v, input int c, input int vw, input int ls);
    int n;
    n = v - (v >> ls) + c;
    if (n > (1 << vw) - 1) n = (1 << vw) - 1;
    return n;
  endfunction

  function automatic logic [W-1:0] fill(input int val);
    logic [W-1:0] r;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = DW'(val);
    return r;
  endfunction

  // Reference model: whole-frame update at acceptance, then a timeline of when each
  // spike element becomes visible and when the frame is offered.
  int v_m [N];
  int refr_m [N];
  bit frame_spk [N];
  logic [W-1:0] exp_so = '0;
  logic exp_sv = 1'b0;
  logic exp_cr = 1'b0;
  int t_m = -1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < N; j++) begin
        v_m[j] = 0;
        refr_m[j] = 0;
      end
      exp_so = '0;
      exp_sv = 1'b0;
      exp_cr = 1'b0;
      t_m = -1;
    end else if (t_m < 0) begin
      if (exp_cr && c_valid) begin
        for (int j = 0; j < N; j++) begin
          int n;
`ifdef LIF_REFRACTORY_EN
          if (refr_m[j] > 0) begin
            refr_m[j]--;
            v_m[j] = 0;
            frame_spk[j] = 1'b0;
          end else begin
`else
          begin
`endif
            n = lif_next(v_m[j], int'(c_in[j*DW +: DW]), VW, LS);
            if (n >= TH) begin
              frame_spk[j] = 1'b1;
              v_m[j] = 0;
              refr_m[j] = 2;
            end else begin
              frame_spk[j] = 1'b0;
              v_m[j] = n;
            end
          end
        end
        t_m = 0;
        exp_cr = 1'b0;
      end else begin
        exp_cr = 1'b1;
      end
    end else if (exp_sv) begin
      if (spike_ready) begin
        exp_sv = 1'b0;
        exp_cr = 1'b1;
        t_m = -1;
      end
    end else begin
      t_m++;
      if (t_m <= N) exp_so[(t_m-1)*DW +: DW] = DW'(frame_spk[t_m-1]);
      if (t_m == N + 1) exp_sv = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("cmp_c_ready", 128'(c_ready), 128'(exp_cr));
    check("cmp_spike_valid", 128'(spike_valid), 128'(exp_sv));
    check("cmp_spike_out", spike_out, exp_so);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    c_valid = 1'b0;
    c8_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic accept_frame(input logic [W-1:0] c);
    int n;
    n = 0;
    c_in = c;
    c_valid = 1'b1;
    while (!c_ready && n < 60) begin
      step();
      n++;
    end
    if (!c_ready) check("accept_timeout", 128'(c_ready), 128'(1));
    step();
    c_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!spike_valid && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic run_frame(input logic [W-1:0] c, input string name, input logic [W-1:0] exp);
    int lat;
    accept_frame(c);
    wait_valid(lat);
    check({name, "_latency"}, 128'(lat), 128'(N + 1));
    check({name, "_spikes"}, spike_out, exp);
  endtask

  task automatic frame8(input logic [W-1:0] c, output logic [W-1:0] spk);
    int n;
    n = 0;
    c8 = c;
    c8_valid = 1'b1;
    while (!c8_ready && n < 60) begin
      step();
      n++;
    end
    step();
    c8_valid = 1'b0;
    n = 0;
    while (!s8_valid && n < 60) begin
      step();
      n++;
    end
    check("sat_valid_latency", 128'(n), 128'(N + 1));
    spk = s8_out;
    step();
  endtask

  initial begin
    int lat;
    int vsum;
    logic [W-1:0] spk8;

    // Reset state
    step();
    check("rst_c_ready", 128'(c_ready), 128'(0));
    check("rst_spike_valid", 128'(spike_valid), 128'(0));
    check("rst_spike_out", spike_out, '0);
    rst = 1'b1;
    step();
    check("c_ready_first_edge", 128'(c_ready), 128'(1));

    // Single frame, consumer ready on entry: one-cycle valid pulse
    run_frame(fill(20), "single", fill(1));
    check("single_model_v", 128'(v_m[0]), 128'(0));
    step();
    check("single_pulse_valid", 128'(spike_valid), 128'(0));
    check("single_pulse_c_ready", 128'(c_ready), 128'(1));

    // Accumulation across two frames
    do_reset();
    run_frame(fill(10), "acc1", fill(0));
    check("acc1_model_v", 128'(v_m[3]), 128'(10));
    check("acc2_model_pin", 128'(lif_next(10, 10, VW, LS)), 128'(18));
    step();
    run_frame(fill(10), "acc2", fill(1));
    step();

    // Backpressure: held output, ignored input
    do_reset();
    spike_ready = 1'b0;
    accept_frame(fill(20));
    wait_valid(lat);
    check("bp_latency", 128'(lat), 128'(N + 1));
    for (int k = 0; k < 10; k++) begin
      c_in = fill(5);
      c_valid = 1'b1;
      step();
      check("bp_valid", 128'(spike_valid), 128'(1));
      check("bp_spikes", spike_out, fill(1));
      check("bp_c_ready", 128'(c_ready), 128'(0));
    end
    c_valid = 1'b0;
    spike_ready = 1'b1;
    step();
    check("bp_exit_valid", 128'(spike_valid), 128'(0));
    check("bp_exit_c_ready", 128'(c_ready), 128'(1));

    // Reset at update index 7
    do_reset();
    accept_frame(fill(20));
    repeat (7) step();
    rst = 1'b0;
    step();
    check("midrst_valid", 128'(spike_valid), 128'(0));
    check("midrst_spikes", spike_out, '0);
    vsum = 0;
    for (int j = 0; j < N; j++) vsum += v_m[j];
    check("midrst_model_v", 128'(vsum), 128'(0));
    rst = 1'b1;
    step();
    repeat (20) begin
      step();
      check("midrst_no_emit", 128'(spike_valid), 128'(0));
    end
    run_frame(fill(10), "midrst_next", fill(0));
    step();

    // Saturation on the 8-bit instance
    do_reset();
    check("sat_model_pin", 128'(lif_next(200, 200, 8, LS)), 128'(255));
    frame8(fill(200), spk8);
    check("sat_frame1", spk8, fill(0));
    frame8(fill(200), spk8);
    check("sat_frame2", spk8, fill(1));

`ifdef LIF_REFRACTORY_EN
    do_reset();
    run_frame(fill(20), "refr1", fill(1));
    step();
    run_frame(fill(20), "refr2", fill(0));
    step();
    run_frame(fill(20), "refr3", fill(0));
    step();
    run_frame(fill(20), "refr4", fill(1));
    step();
`endif

    // Randomized traffic with backpressure, stray c_valid and occasional resets
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      c_valid = ($urandom_range(0, 1) == 1);
      for (int j = 0; j < N; j++) c_in[j*DW +: DW] = DW'($urandom_range(0, 12));
      spike_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) != 0);
      step();
    end
    rst = 1'b1;
    c_valid = 1'b0;
    spike_ready = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
